// File: rtl/cache_pkg.sv
// Shared types and address-field width helpers for the two-way associative cache.
package cache_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MISS_REQ,
        S_REFILL,
        S_WRITE,
        S_RESP
    } cache_state_e;

    function automatic int unsigned word_bits(input int unsigned words);
        return $clog2(words);
    endfunction

    function automatic int unsigned set_bits(input int unsigned sets);
        return $clog2(sets);
    endfunction

    function automatic int unsigned tag_bits(input int unsigned addr_w,
                                             input int unsigned sets,
                                             input int unsigned words);
        return addr_w - 2 - $clog2(words) - $clog2(sets);
    endfunction

endpackage

// File: rtl/cache_way.sv
// One cache way: valid/tag/data arrays, combinational tag match and word read,
// a single-word write port and a line-fill write port.
module cache_way
    import cache_pkg::*;
#(
    parameter int unsigned TAG_W  = 27,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned SETS   = 2,
    parameter int unsigned WORDS  = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [set_bits(SETS)-1:0]      set_i,
    input  logic [TAG_W-1:0]               tag_i,
    input  logic [word_bits(WORDS)-1:0]    rd_word_i,
    output logic                           hit_o,
    output logic                           valid_o,
    output logic [DATA_W-1:0]              rdata_o,
    input  logic                           wr_en_i,
    input  logic [word_bits(WORDS)-1:0]    wr_word_i,
    input  logic [DATA_W-1:0]              wr_data_i,
    input  logic                           fill_en_i,
    input  logic [word_bits(WORDS)-1:0]    fill_word_i,
    input  logic [DATA_W-1:0]              fill_data_i,
    input  logic                           fill_last_i
);

    logic [SETS-1:0]   valid_q;
    logic [TAG_W-1:0]  tag_q  [SETS];
    logic [DATA_W-1:0] data_q [SETS][WORDS];

    assign valid_o = valid_q[set_i];
    assign hit_o   = valid_q[set_i] && (tag_q[set_i] == tag_i);
    assign rdata_o = data_q[set_i][rd_word_i];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else if (fill_en_i && fill_last_i) begin
            valid_q[set_i] <= 1'b1;
        end
    end

    // Tag/data need no reset: a line is only visible once its valid bit is set.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            data_q[set_i][wr_word_i] <= wr_data_i;
        end
        if (fill_en_i) begin
            data_q[set_i][fill_word_i] <= fill_data_i;
            if (fill_last_i) begin
                tag_q[set_i] <= tag_i;
            end
        end
    end

endmodule

// File: rtl/assoc_cache.sv
// Two-way set-associative write-through cache with per-set LRU and line refill.
// Define CACHE_STATS_EN to add saturating load hit/miss counters.
module assoc_cache
    import cache_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned SETS   = 2,
    parameter int unsigned WORDS  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_we_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [DATA_W-1:0] req_wdata_i,
    output logic              rsp_valid_o,
    output logic [DATA_W-1:0] rsp_rdata_o,
    output logic              mem_req_valid_o,
    input  logic              mem_req_ready_i,
    output logic              mem_req_we_o,
    output logic [ADDR_W-1:0] mem_req_addr_o,
    output logic [DATA_W-1:0] mem_req_wdata_o,
    input  logic              mem_rsp_valid_i,
    input  logic [DATA_W-1:0] mem_rsp_rdata_i
`ifdef CACHE_STATS_EN
    ,
    output logic [31:0]       hit_cnt_o,
    output logic [31:0]       miss_cnt_o
`endif
);

    localparam int unsigned WB    = word_bits(WORDS);
    localparam int unsigned SB    = set_bits(SETS);
    localparam int unsigned TAG_W = tag_bits(ADDR_W, SETS, WORDS);
    localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(WORDS * 4 - 1);
    localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(3);

    cache_state_e      state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              victim_q, victim_d;
    logic              hitpulse_q, hitpulse_d;
    logic [WB-1:0]     beat_q, beat_d;
    logic [SETS-1:0]   lru_q, lru_d;

    logic [WB-1:0]     req_word, q_word;
    logic [SB-1:0]     req_set, q_set, way_set;
    logic [TAG_W-1:0]  req_tag, q_tag, way_tag;
    logic [1:0]        hit, way_valid, wr_en, fill_en;
    logic [DATA_W-1:0] way_rdata [2];
    logic              accept, any_hit, hit_way, victim, beat_in, last_beat;

    assign req_word  = req_addr_i[2 +: WB];
    assign req_set   = req_addr_i[2 + WB +: SB];
    assign req_tag   = req_addr_i[ADDR_W-1 -: TAG_W];
    assign q_word    = addr_q[2 +: WB];
    assign q_set     = addr_q[2 + WB +: SB];
    assign q_tag     = addr_q[ADDR_W-1 -: TAG_W];

    assign accept    = req_valid_i && (state_q == S_IDLE);
    assign way_set   = (state_q == S_IDLE) ? req_set : q_set;
    assign way_tag   = (state_q == S_IDLE) ? req_tag : q_tag;
    assign any_hit   = |hit;
    assign hit_way   = hit[1];
    assign victim    = !way_valid[0] ? 1'b0 : (!way_valid[1] ? 1'b1 : lru_q[req_set]);
    assign beat_in   = (state_q == S_REFILL) && mem_rsp_valid_i;
    assign last_beat = (beat_q == '1);

    for (genvar g = 0; g < 2; g++) begin : g_way
        assign wr_en[g]   = accept && req_we_i && hit[g];
        assign fill_en[g] = beat_in && (victim_q == 1'(g));

        cache_way #(
            .TAG_W (TAG_W),
            .DATA_W(DATA_W),
            .SETS  (SETS),
            .WORDS (WORDS)
        ) u_way (
            .clk        (clk),
            .rst_n      (rst_n),
            .set_i      (way_set),
            .tag_i      (way_tag),
            .rd_word_i  (req_word),
            .hit_o      (hit[g]),
            .valid_o    (way_valid[g]),
            .rdata_o    (way_rdata[g]),
            .wr_en_i    (wr_en[g]),
            .wr_word_i  (req_word),
            .wr_data_i  (req_wdata_i),
            .fill_en_i  (fill_en[g]),
            .fill_word_i(beat_q),
            .fill_data_i(mem_rsp_rdata_i),
            .fill_last_i(last_beat)
        );
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            victim_q   <= 1'b0;
            hitpulse_q <= 1'b0;
            beat_q     <= '0;
            lru_q      <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            victim_q   <= victim_d;
            hitpulse_q <= hitpulse_d;
            beat_q     <= beat_d;
            lru_q      <= lru_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:     if (accept) begin
                            if (req_we_i)      state_d = S_WRITE;
                            else if (!any_hit) state_d = S_MISS_REQ;
                        end
            S_MISS_REQ: if (mem_req_ready_i) state_d = S_REFILL;
            S_REFILL:   if (mem_rsp_valid_i && last_beat) state_d = S_RESP;
            S_WRITE:    if (mem_req_ready_i) state_d = S_RESP;
            S_RESP:     state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    always_comb begin
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        victim_d   = victim_q;
        hitpulse_d = 1'b0;
        beat_d     = beat_q;
        lru_d      = lru_q;
        if (accept) begin
            addr_d   = req_addr_i;
            wdata_d  = req_wdata_i;
            victim_d = victim;
            if (req_we_i) begin
                rdata_d = '0;
                if (any_hit) lru_d[req_set] = ~hit_way;
            end else if (any_hit) begin
                rdata_d        = way_rdata[hit_way];
                hitpulse_d     = 1'b1;
                lru_d[req_set] = ~hit_way;
            end
        end
        if (beat_in) begin
            beat_d = beat_q + 1'b1;
            if (beat_q == q_word) rdata_d = mem_rsp_rdata_i;
            if (last_beat)        lru_d[q_set] = ~victim_q;
        end
    end

    always_comb begin
        req_ready_o     = (state_q == S_IDLE);
        rsp_valid_o     = hitpulse_q;
        rsp_rdata_o     = rdata_q;
        mem_req_valid_o = 1'b0;
        mem_req_we_o    = 1'b0;
        mem_req_addr_o  = '0;
        mem_req_wdata_o = '0;
        case (state_q)
            S_MISS_REQ: begin
                mem_req_valid_o = 1'b1;
                mem_req_addr_o  = addr_q & LINE_MASK;
            end
            S_WRITE: begin
                mem_req_valid_o = 1'b1;
                mem_req_we_o    = 1'b1;
                mem_req_addr_o  = addr_q & WORD_MASK;
                mem_req_wdata_o = wdata_q;
            end
            S_RESP:  rsp_valid_o = 1'b1;
            default: ;
        endcase
    end

`ifdef CACHE_STATS_EN
    logic [31:0] hit_cnt_q, miss_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else if (accept && !req_we_i) begin
            if (any_hit && hit_cnt_q != '1)   hit_cnt_q  <= hit_cnt_q + 1'b1;
            if (!any_hit && miss_cnt_q != '1) miss_cnt_q <= miss_cnt_q + 1'b1;
        end
    end

    assign hit_cnt_o  = hit_cnt_q;
    assign miss_cnt_o = miss_cnt_q;
`endif

endmodule

// File: tb/tb_assoc_cache.sv
// Directed bench for assoc_cache with a reference memory and a response queue.
module tb_assoc_cache;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic        req_we_i = 1'b0;
    logic [31:0] req_addr_i = '0;
    logic [31:0] req_wdata_i = '0;
    logic        rsp_valid_o;
    logic [31:0] rsp_rdata_o;
    logic        mem_req_valid_o;
    logic        mem_req_ready_i = 1'b0;
    logic        mem_req_we_o;
    logic [31:0] mem_req_addr_o;
    logic [31:0] mem_req_wdata_o;
    logic        mem_rsp_valid_i = 1'b0;
    logic [31:0] mem_rsp_rdata_i = '0;
`ifdef CACHE_STATS_EN
    logic [31:0] hit_cnt_o, miss_cnt_o;
`endif

    int unsigned checks = 0;
    int unsigned errors = 0;
    logic [31:0] expq [$];
    logic [31:0] bmem [logic [31:0]];

    always #5 clk = ~clk;

    assoc_cache #(.ADDR_W(32), .DATA_W(32), .SETS(2), .WORDS(4)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid_i    (req_valid_i),
        .req_ready_o    (req_ready_o),
        .req_we_i       (req_we_i),
        .req_addr_i     (req_addr_i),
        .req_wdata_i    (req_wdata_i),
        .rsp_valid_o    (rsp_valid_o),
        .rsp_rdata_o    (rsp_rdata_o),
        .mem_req_valid_o(mem_req_valid_o),
        .mem_req_ready_i(mem_req_ready_i),
        .mem_req_we_o   (mem_req_we_o),
        .mem_req_addr_o (mem_req_addr_o),
        .mem_req_wdata_o(mem_req_wdata_o),
        .mem_rsp_valid_i(mem_rsp_valid_i),
        .mem_rsp_rdata_i(mem_rsp_rdata_i)
`ifdef CACHE_STATS_EN
        ,
        .hit_cnt_o      (hit_cnt_o),
        .miss_cnt_o     (miss_cnt_o)
`endif
    );

    // Unwritten words read as (word index + 0x90), so 0x40..0x4C hold 0xA0..0xA3.
    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (bmem.exists(a)) return bmem[a];
        return (a >> 2) + 32'h90;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_rsp(input string tag);
        logic [31:0] e;
        if (expq.size() == 0) begin
            chk({tag, "_queue_empty"}, 32'd1, 32'd0);
        end else begin
            e = expq.pop_front();
            chk(tag, rsp_rdata_o, e);
        end
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_req_ready"}, {31'd0, req_ready_o}, 32'd1);
        chk({tag, "_rsp_valid"}, {31'd0, rsp_valid_o}, 32'd0);
        chk({tag, "_rsp_rdata"}, rsp_rdata_o, 32'd0);
        chk({tag, "_mreq_valid"}, {31'd0, mem_req_valid_o}, 32'd0);
        chk({tag, "_mreq_we"}, {31'd0, mem_req_we_o}, 32'd0);
        chk({tag, "_mreq_addr"}, mem_req_addr_o, 32'd0);
        chk({tag, "_mreq_wdata"}, mem_req_wdata_o, 32'd0);
    endtask

    // One CPU access; loads expected to hit respond in the next cycle with no memory request.
    task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                          input bit exp_hit, input int stall);
        logic [31:0] line, waddr, maddr;
        line  = addr & ~32'hF;
        waddr = addr & ~32'h3;
        maddr = we ? waddr : line;
        chk("req_ready", {31'd0, req_ready_o}, 32'd1);
        req_valid_i = 1'b1;
        req_we_i    = we;
        req_addr_i  = addr;
        req_wdata_i = wd;
        if (we) begin
            expq.push_back(32'd0);
            bmem[waddr] = wd;
        end else begin
            expq.push_back(mem_rd(waddr));
        end
        tick();
        req_valid_i = 1'b0;
        if (!we && exp_hit) begin
            chk("hit_no_mreq", {31'd0, mem_req_valid_o}, 32'd0);
            chk("hit_rsp_valid", {31'd0, rsp_valid_o}, 32'd1);
            check_rsp("hit_rdata");
        end else begin
            // A request presented while busy must be ignored.
            req_valid_i = 1'b1;
            req_addr_i  = addr ^ 32'h1000;
            chk("busy_ready", {31'd0, req_ready_o}, 32'd0);
            for (int i = 0; i < stall; i++) begin
                chk("stall_valid", {31'd0, mem_req_valid_o}, 32'd1);
                chk("stall_addr", mem_req_addr_o, maddr);
                chk("stall_we", {31'd0, mem_req_we_o}, {31'd0, we});
                tick();
            end
            chk("mreq_valid", {31'd0, mem_req_valid_o}, 32'd1);
            chk("mreq_we", {31'd0, mem_req_we_o}, {31'd0, we});
            chk("mreq_addr", mem_req_addr_o, maddr);
            chk("mreq_wdata", mem_req_wdata_o, we ? wd : 32'd0);
            mem_req_ready_i = 1'b1;
            tick();
            mem_req_ready_i = 1'b0;
            req_valid_i     = 1'b0;
            if (!we) begin
                for (int k = 0; k < 4; k++) begin
                    mem_rsp_valid_i = 1'b1;
                    mem_rsp_rdata_i = mem_rd(line + 32'(4 * k));
                    tick();
                end
                mem_rsp_valid_i = 1'b0;
            end
            chk("rsp_valid", {31'd0, rsp_valid_o}, 32'd1);
            check_rsp(we ? "store_rdata" : "miss_rdata");
            tick();
            chk("rsp_one_cycle", {31'd0, rsp_valid_o}, 32'd0);
        end
    endtask

    initial begin
        tick();
        tick();
        check_reset_state("in_reset");
        rst_n = 1'b1;
        tick();
        check_reset_state("after_reset");

        // Cold miss, then a hit in the same line.
        access(1'b0, 32'h40, '0, 1'b0, 0);
        access(1'b0, 32'h48, '0, 1'b1, 0);

        // LRU: 0xC0 evicts the 0x80 line, which was least recently used.
        access(1'b0, 32'h80, '0, 1'b0, 0);
        access(1'b0, 32'h40, '0, 1'b1, 0);
        access(1'b0, 32'hC0, '0, 1'b0, 0);
        access(1'b0, 32'h40, '0, 1'b1, 0);
        access(1'b0, 32'h80, '0, 1'b0, 0);
`ifdef CACHE_STATS_EN
        chk("hit_cnt", hit_cnt_o, 32'd3);
        chk("miss_cnt", miss_cnt_o, 32'd4);
`endif

        // Store hit updates the line; back-to-back load hits.
        access(1'b1, 32'h44, 32'hDEADBEEF, 1'b1, 0);
        access(1'b0, 32'h44, '0, 1'b1, 0);
        access(1'b0, 32'h48, '0, 1'b1, 0);
        access(1'b0, 32'h4C, '0, 1'b1, 0);
        access(1'b0, 32'h84, '0, 1'b1, 0);

        // Store miss with memory backpressure; no allocate, so the load misses.
        access(1'b1, 32'h100, 32'h11, 1'b0, 5);
        access(1'b0, 32'h100, '0, 1'b0, 0);

        // Reset in the middle of a refill, with beats continuing through and after it.
        chk("rr_ready", {31'd0, req_ready_o}, 32'd1);
        req_valid_i = 1'b1;
        req_we_i    = 1'b0;
        req_addr_i  = 32'h200;
        tick();
        req_valid_i = 1'b0;
        chk("rr_mreq_valid", {31'd0, mem_req_valid_o}, 32'd1);
        mem_req_ready_i = 1'b1;
        tick();
        mem_req_ready_i = 1'b0;
        for (int k = 0; k < 2; k++) begin
            mem_rsp_valid_i = 1'b1;
            mem_rsp_rdata_i = 32'h5A5A_0000 + 32'(k);
            tick();
        end
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        mem_rsp_valid_i = 1'b0;
        check_reset_state("mid_refill_reset");
`ifdef CACHE_STATS_EN
        chk("hit_cnt_reset", hit_cnt_o, 32'd0);
        chk("miss_cnt_reset", miss_cnt_o, 32'd0);
`endif
        access(1'b0, 32'h40, '0, 1'b0, 0);
        access(1'b0, 32'h44, '0, 1'b1, 0);
        chk("queue_drained", 32'(expq.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
